// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) for a single non-pipelined memory port.
// One transaction in flight: IDLE accepts, ISSUE hands off downstream, WAIT returns the response.
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                last_ls;
  logic                owner_ls;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [MASK_W-1:0]   req_wmask;
  logic                grant_if, grant_ls, accept, resp_take;

  // Tie-break: fixed LS priority, or alternate away from the previous winner.
  function automatic logic pick_ls(input logic if_v, input logic ls_v, input logic last_was_ls);
    if (!ls_v) return 1'b0;
    if (!if_v) return 1'b1;
    if (LSU_PRIO) return 1'b1;
    return !last_was_ls;
  endfunction

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    case (state)
      IDLE: begin
        grant_ls = pick_ls(if_req_valid, ls_req_valid, last_ls);
        grant_if = if_req_valid && !grant_ls;
        if (grant_if || grant_ls) state_nxt = ISSUE;
      end
      ISSUE: if (mem_req_ready) state_nxt = WAIT;
      WAIT:  if (mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = grant_if || grant_ls;
  assign resp_take = (state == WAIT) && mem_resp_valid;

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign mem_req_valid = (state == ISSUE);
  assign mem_we        = req_we;
  assign mem_addr      = req_addr;
  assign mem_wdata     = req_wdata;
  assign mem_wmask     = req_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_ls       <= 1'b1;
      owner_ls      <= 1'b0;
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_wmask     <= '0;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if_rdata      <= '0;
      ls_rdata      <= '0;
    end else begin
      state         <= state_nxt;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      // Accept stage: capture the winner so later upstream changes cannot disturb it.
      if (accept) begin
        owner_ls  <= grant_ls;
        last_ls   <= grant_ls;
        req_we    <= grant_ls && ls_we;
        req_addr  <= grant_ls ? ls_addr : if_addr;
        req_wdata <= grant_ls ? ls_wdata : '0;
        req_wmask <= (grant_ls && ls_we) ? ls_wmask : '0;
      end
      // Response stage: only a response seen in WAIT belongs to the current owner.
      if (resp_take) begin
        if (owner_ls) begin
          ls_resp_valid <= 1'b1;
          ls_rdata      <= req_we ? '0 : mem_rdata;
        end else begin
          if_resp_valid <= 1'b1;
          if_rdata      <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a fixed-priority and a round-robin instance share all inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, ls_req_valid, ls_we;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_ready, mem_resp_valid;

  logic        p_if_ready, p_if_resp, p_ls_ready, p_ls_resp, p_mem_valid, p_mem_we;
  logic [63:0] p_if_rdata, p_ls_rdata, p_mem_addr, p_mem_wdata;
  logic [7:0]  p_mem_wmask;
  logic        r_if_ready, r_if_resp, r_ls_ready, r_ls_resp, r_mem_valid, r_mem_we;
  logic [63:0] r_if_rdata, r_ls_rdata, r_mem_addr, r_mem_wdata;
  logic [7:0]  r_mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LSU_PRIO(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(p_if_ready), .if_addr(if_addr),
    .if_resp_valid(p_if_resp), .if_rdata(p_if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(p_ls_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(p_ls_resp), .ls_rdata(p_ls_rdata),
    .mem_req_valid(p_mem_valid), .mem_req_ready(mem_req_ready), .mem_we(p_mem_we),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_wmask(p_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LSU_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(r_if_ready), .if_addr(if_addr),
    .if_resp_valid(r_if_resp), .if_rdata(r_if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(r_ls_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(r_ls_resp), .ls_rdata(r_ls_rdata),
    .mem_req_valid(r_mem_valid), .mem_req_ready(mem_req_ready), .mem_we(r_mem_we),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_wmask(r_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Downstream model: accept in ISSUE this cycle, answer with rd the next cycle.
  task automatic serve(input logic [63:0] rd);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    step();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_req_valid = 0; ls_req_valid = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    do_reset();

    // Reset state
    check_eq("rst_mem_valid", p_mem_valid, 0);
    check_eq("rst_if_resp",   p_if_resp, 0);
    check_eq("rst_ls_resp",   p_ls_resp, 0);
    check_eq("rst_if_rdata",  p_if_rdata, 0);
    check_eq("rst_mem_addr",  p_mem_addr, 0);
    check_eq("rst_if_ready",  p_if_ready, 0);

    // Single IF read
    if_req_valid = 1; if_addr = 64'h8000_0000;
    #1;
    check_eq("if1_ready",    p_if_ready, 1);
    check_eq("if1_ls_ready", p_ls_ready, 0);
    step();
    if_req_valid = 0;
    check_eq("if1_mem_valid", p_mem_valid, 1);
    check_eq("if1_mem_addr",  p_mem_addr, 64'h8000_0000);
    check_eq("if1_mem_we",    p_mem_we, 0);
    check_eq("if1_mem_wmask", p_mem_wmask, 0);
    check_eq("if1_busy_rdy",  p_if_ready, 0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    check_eq("if1_wait_valid", p_mem_valid, 0);
    check_eq("if1_early_resp", p_if_resp, 0);
    mem_resp_valid = 1; mem_rdata = 64'h0010_0073;
    step();
    mem_resp_valid = 0;
    check_eq("if1_resp",  p_if_resp, 1);
    check_eq("if1_rdata", p_if_rdata, 64'h0010_0073);
    check_eq("if1_ls_resp", p_ls_resp, 0);
    step();
    check_eq("if1_pulse_end", p_if_resp, 0);
    check_eq("if1_rdata_hold", p_if_rdata, 64'h0010_0073);

    // LS write
    ls_req_valid = 1; ls_we = 1; ls_addr = 64'h8000_1000;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    #1;
    check_eq("wr_ready", p_ls_ready, 1);
    step();
    ls_req_valid = 0;
    check_eq("wr_mem_we",    p_mem_we, 1);
    check_eq("wr_mem_addr",  p_mem_addr, 64'h8000_1000);
    check_eq("wr_mem_wdata", p_mem_wdata, 64'hDEAD_BEEF);
    check_eq("wr_mem_wmask", p_mem_wmask, 8'h0F);
    serve(64'h1234_5678);
    check_eq("wr_resp",    p_ls_resp, 1);
    check_eq("wr_rdata",   p_ls_rdata, 0);
    check_eq("wr_if_resp", p_if_resp, 0);
    ls_we = 0;

    // Tie: both valid right after reset
    do_reset();
    if_req_valid = 1; if_addr = 64'h100;
    ls_req_valid = 1; ls_addr = 64'h200; ls_we = 0;
    #1;
    check_eq("tie_p_ls_ready", p_ls_ready, 1);
    check_eq("tie_p_if_ready", p_if_ready, 0);
    check_eq("tie_r_if_ready", r_if_ready, 1);
    check_eq("tie_r_ls_ready", r_ls_ready, 0);
    step();
    check_eq("tie_p_addr", p_mem_addr, 64'h200);
    check_eq("tie_r_addr", r_mem_addr, 64'h100);
    serve(64'hAAAA);
    check_eq("tie_p_ls_resp",  p_ls_resp, 1);
    check_eq("tie_p_ls_rdata", p_ls_rdata, 64'hAAAA);
    check_eq("tie_r_if_resp",  r_if_resp, 1);
    check_eq("tie_r_if_rdata", r_if_rdata, 64'hAAAA);
    // Back-to-back accept in the response cycle; round-robin now favours LS
    check_eq("tie2_p_ls_ready", p_ls_ready, 1);
    check_eq("tie2_r_ls_ready", r_ls_ready, 1);
    check_eq("tie2_r_if_ready", r_if_ready, 0);
    step();
    check_eq("tie2_r_addr", r_mem_addr, 64'h200);
    serve(64'hBBBB);
    check_eq("tie2_r_ls_resp",  r_ls_resp, 1);
    check_eq("tie2_r_ls_rdata", r_ls_rdata, 64'hBBBB);
    ls_req_valid = 0;
    #1;
    check_eq("tie3_p_if_ready", p_if_ready, 1);
    step();
    if_req_valid = 0;
    check_eq("tie3_p_addr", p_mem_addr, 64'h100);
    serve(64'hCCCC);
    check_eq("tie3_p_if_resp",  p_if_resp, 1);
    check_eq("tie3_p_if_rdata", p_if_rdata, 64'hCCCC);

    // Downstream stall for 5 cycles
    ls_req_valid = 1; ls_we = 1; ls_addr = 64'h8000_2000;
    ls_wdata = 64'h55AA; ls_wmask = 8'hF0;
    step();
    if_req_valid = 1; if_addr = 64'h999;
    ls_addr = 64'h4444; ls_wdata = 64'h0; ls_wmask = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", p_mem_valid, 1);
      check_eq("stall_addr",  p_mem_addr, 64'h8000_2000);
      check_eq("stall_wdata", p_mem_wdata, 64'h55AA);
      check_eq("stall_wmask", p_mem_wmask, 8'hF0);
      check_eq("stall_if_rdy", p_if_ready, 0);
      check_eq("stall_ls_rdy", p_ls_ready, 0);
      step();
    end
    if_req_valid = 0; ls_req_valid = 0; ls_we = 0;
    serve(64'h0);
    check_eq("stall_resp", p_ls_resp, 1);

    // Reset while waiting for the response
    if_req_valid = 1; if_addr = 64'h300;
    step();
    if_req_valid = 0;
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    rst = 1;
    step();
    rst = 0;
    mem_resp_valid = 1; mem_rdata = 64'hBAD;
    step();
    mem_resp_valid = 0;
    check_eq("rstw_if_resp",   p_if_resp, 0);
    check_eq("rstw_ls_resp",   p_ls_resp, 0);
    check_eq("rstw_if_rdata",  p_if_rdata, 0);
    check_eq("rstw_mem_valid", p_mem_valid, 0);
    if_req_valid = 1; if_addr = 64'h8000_0004;
    #1;
    check_eq("rstw_idle_ready", p_if_ready, 1);
    step();
    if_req_valid = 0;
    check_eq("rstw_addr", p_mem_addr, 64'h8000_0004);
    serve(64'h777);
    check_eq("rstw_resp",  p_if_resp, 1);
    check_eq("rstw_rdata", p_if_rdata, 64'h777);

    // Stray response while idle
    step();
    mem_resp_valid = 1; mem_rdata = 64'hFFFF;
    step();
    mem_resp_valid = 0;
    check_eq("stray_if_resp",  p_if_resp, 0);
    check_eq("stray_ls_resp",  p_ls_resp, 0);
    check_eq("stray_if_rdata", p_if_rdata, 64'h777);
    check_eq("stray_ls_rdata", p_ls_rdata, 0);
    check_eq("stray_mem_valid", p_mem_valid, 0);
    if_req_valid = 1;
    #1;
    check_eq("stray_idle_ready", p_if_ready, 1);
    if_req_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
